// File: rtl/adc_cfg_sequencer.sv
// adc_cfg_sequencer: walks an external init table, then serves single-word
// host writes, feeding one 32-bit word at a time to a byte-serialising
// register splitter and waiting for its byte strobes (with timeout).
module adc_cfg_sequencer #(
  parameter int INIT_WORDS     = 4,
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  init_addr,
  input  logic [31:0] init_data,
  input  logic        host_req,
  input  logic [31:0] host_word,
  output logic        host_ack,
  output logic        split_write,
  output logic [31:0] split_word,
  input  logic        split_enable,
  output logic        busy,
  output logic        init_done,
  output logic        error
);
  localparam int             BW        = $clog2(BYTES_PER_WORD + 1);
  localparam logic [BW-1:0]  BCNT_LAST = BW'(BYTES_PER_WORD);
  // tcnt holds the count of completed WAIT cycles; the cycle in which it
  // would reach TIMEOUT is the last one we wait.
  localparam logic [7:0]     TCNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0]     IDX_LAST  = 4'(INIT_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, GAP} state_t;
  typedef enum logic {SRC_INIT, SRC_HOST} src_t;

  state_t          state, state_nxt;
  src_t            src, src_nxt;
  logic [3:0]      idx, idx_nxt;
  logic [BW-1:0]   bcnt, bcnt_nxt, bcnt_inc;
  logic [7:0]      tcnt, tcnt_nxt;
  logic [31:0]     word_nxt;
  logic            done_nxt, err_nxt;

  assign bcnt_inc  = bcnt + BW'(split_enable);
  assign busy      = (state != IDLE);
  assign init_addr = idx;

  // State and datapath registers; reset drops everything, aborted words are not resumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      src        <= SRC_INIT;
      idx        <= '0;
      bcnt       <= '0;
      tcnt       <= '0;
      split_word <= '0;
      init_done  <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nxt;
      src        <= src_nxt;
      idx        <= idx_nxt;
      bcnt       <= bcnt_nxt;
      tcnt       <= tcnt_nxt;
      split_word <= word_nxt;
      init_done  <= done_nxt;
      error      <= err_nxt;
    end
  end

  // Next-state, arbitration and strobe outputs; strobes outside WAIT are ignored.
  always_comb begin
    state_nxt   = state;
    src_nxt     = src;
    idx_nxt     = idx;
    bcnt_nxt    = bcnt;
    tcnt_nxt    = tcnt;
    word_nxt    = split_word;
    done_nxt    = init_done;
    err_nxt     = error;
    split_write = 1'b0;
    host_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt   = '0;
          src_nxt   = SRC_INIT;
          done_nxt  = 1'b0;
          err_nxt   = 1'b0;
          state_nxt = LOAD;
        end else if (host_req) begin
          src_nxt   = SRC_HOST;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        word_nxt  = (src == SRC_INIT) ? init_data : host_word;
        bcnt_nxt  = '0;
        tcnt_nxt  = '0;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        split_write = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        bcnt_nxt = bcnt_inc;
        tcnt_nxt = tcnt + 8'd1;
        // A final strobe in the last allowed cycle still completes the word.
        if (bcnt_inc == BCNT_LAST) begin
          state_nxt = GAP;
        end else if (tcnt == TCNT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      GAP: begin
        if (src == SRC_HOST) begin
          host_ack  = 1'b1;
          state_nxt = IDLE;
        end else if (idx == IDX_LAST) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          idx_nxt   = idx + 4'd1;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Bench for adc_cfg_sequencer: a splitter model answers each write with byte
// strobes, stimulus pushes the words the sequence should produce, and a
// negedge monitor pops and compares every split_write / host_ack.
module tb_adc_cfg_sequencer;
  localparam int N  = 4;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, host_req = 1'b0;
  logic [31:0] host_word = '0;
  logic        spl_en = 1'b0, stray_en = 1'b0;
  logic        split_enable, host_ack, split_write, busy, init_done, error;
  logic [3:0]  init_addr;
  logic [31:0] init_data, split_word;
  logic [31:0] rom [16];
  int          short_addr = -1;

  assign split_enable = spl_en | stray_en;
  assign init_data    = rom[init_addr];

  always #5 clk = ~clk;

  adc_cfg_sequencer #(.INIT_WORDS(N), .BYTES_PER_WORD(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .init_addr(init_addr),
    .init_data(init_data), .host_req(host_req), .host_word(host_word),
    .host_ack(host_ack), .split_write(split_write), .split_word(split_word),
    .split_enable(split_enable), .busy(busy), .init_done(init_done),
    .error(error)
  );

  typedef struct {logic [31:0] word; logic is_init; int addr;} exp_t;
  exp_t        exp_q[$];
  logic [31:0] ack_q[$];
  exp_t        mon_e;
  logic [31:0] mon_w;
  int pass_cnt = 0, tot_cnt = 0;
  int cyc = 0, last_strobe = -100, last_wr = -100, strobe_cnt = 0, wr_cnt = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  task automatic fail(string nm);
    tot_cnt++;
    $display("FAIL %s got=none exp=event", nm);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: compare each presented word and each ack against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (spl_en) begin last_strobe = cyc; strobe_cnt++; end
    if (split_write === 1'b1) begin
      wr_cnt++;
      last_wr = cyc;
      if (exp_q.size() == 0) fail("unexpected_write");
      else begin
        mon_e = exp_q.pop_front();
        chk("split_word", split_word, mon_e.word);
        if (mon_e.is_init) begin
          chk("init_addr", init_addr, mon_e.addr);
          if (mon_e.addr > 0) chk("issue_after_strobe", cyc - last_strobe, 3);
        end else ack_q.push_back(mon_e.word);
      end
      strobe_cnt = 0;
    end
    if (host_ack === 1'b1) begin
      if (ack_q.size() == 0) fail("unexpected_ack");
      else begin
        mon_w = ack_q.pop_front();
        chk("ack_word", split_word, mon_w);
        chk("ack_after_strobe", cyc - last_strobe, 1);
        chk("ack_strobes", strobe_cnt, 4);
      end
    end
  end

  // Splitter model: 4 strobes per word with random gaps, only 3 for short_addr.
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (split_write === 1'b1) begin
        n = (short_addr >= 0 && int'(init_addr) == short_addr) ? 3 : 4;
        tick();
        for (int k = 0; k < n; k++) begin
          repeat ($urandom_range(0, 2)) tick();
          spl_en = 1'b1;
          tick();
          spl_en = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(string nm);
    int c = 0;
    while (busy && c < 3000) begin tick(); c++; end
    if (busy) fail(nm);
  endtask

  task automatic wait_ack(string nm);
    int c = 0;
    do begin @(negedge clk); c++; end while (host_ack !== 1'b1 && c < 3000);
    host_req = 1'b0;
    if (host_ack !== 1'b1) fail(nm);
  endtask

  // Full init run; short >= 0 makes that entry time out and ends the sequence.
  task automatic run_init(int sh);
    int last, c0, w0, c;
    last = (sh < 0) ? N - 1 : sh;
    for (int i = 0; i <= last; i++) exp_q.push_back('{rom[i], 1'b1, i});
    c0 = cyc; w0 = wr_cnt;
    start = 1'b1; tick(); start = 1'b0;
    c = 0;
    while (wr_cnt == w0 && c < 50) begin tick(); c++; end
    chk("start_latency", last_wr - c0, 3);
    if (sh >= 0) begin
      c = 0;
      while (wr_cnt < w0 + sh + 1 && c < 500) begin tick(); c++; end
    end
    wait_idle("init_idle");
    if (sh >= 0) chk("timeout_latency", cyc - last_wr, TO);
    chk("init_done", init_done, (sh < 0));
    chk("error", error, (sh >= 0));
    chk("final_addr", init_addr, last);
    chk("init_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_host(logic [31:0] w, bit lat);
    int c0;
    exp_q.push_back('{w, 1'b0, 0});
    host_word = w; host_req = 1'b1; c0 = cyc;
    wait_ack("host_ack_wait");
    if (lat) chk("host_latency", last_wr - c0, 3);
    tick();
    chk("host_idle", busy, 0);
  endtask

  initial begin
    int w0, c;
    logic [31:0] hw;
    #2 rst = 1'b0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_write", split_write, 0);
    chk("rst_word", split_word, 0);
    chk("rst_addr", init_addr, 0);
    chk("rst_done", init_done, 0);
    chk("rst_error", error, 0);
    chk("rst_ack", host_ack, 0);
    rst = 1'b1;
    tick(2);

    // Directed init table, then a host write.
    rom[0] = 32'h57494E20; rom[1] = 32'h12345678;
    rom[2] = 32'hA5A5A5A5; rom[3] = 32'h00000001;
    for (int j = 4; j < 16; j++) rom[j] = $urandom;
    run_init(-1);
    do_host(32'hDEADBEEF, 1'b1);

    // Host request and stray start while entry 1 is in flight.
    hw = $urandom;
    for (int i = 0; i < N; i++) exp_q.push_back('{rom[i], 1'b1, i});
    exp_q.push_back('{hw, 1'b0, 0});
    start = 1'b1; tick(); start = 1'b0;
    w0 = wr_cnt; c = 0;
    while (wr_cnt < w0 + 2 && c < 200) begin tick(); c++; end
    host_word = hw; host_req = 1'b1; start = 1'b1; tick(); start = 1'b0;
    wait_ack("overlap_ack");
    chk("done_before_host", init_done, 1);
    tick();
    wait_idle("overlap_idle");
    chk("overlap_queue_empty", exp_q.size(), 0);

    // Timeout on entry 2, then a clean rerun clears error.
    short_addr = 2;
    run_init(2);
    short_addr = -1;
    run_init(-1);

    // Reset in WAIT.
    for (int i = 0; i < N; i++) exp_q.push_back('{rom[i], 1'b1, i});
    w0 = wr_cnt;
    start = 1'b1; tick(); start = 1'b0;
    c = 0;
    while (wr_cnt == w0 && c < 50) begin tick(); c++; end
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_write", split_write, 0);
    chk("arst_word", split_word, 0);
    chk("arst_addr", init_addr, 0);
    chk("arst_done", init_done, 0);
    chk("arst_error", error, 0);
    exp_q.delete();
    ack_q.delete();
    tick(2);
    rst = 1'b1;
    w0 = wr_cnt;
    tick(30);
    chk("no_write_after_rst", wr_cnt - w0, 0);

    // Stray strobes in IDLE must not pre-load the byte count.
    repeat (3) begin stray_en = 1'b1; tick(); stray_en = 1'b0; tick(); end
    chk("stray_idle", busy, 0);
    do_host($urandom, 1'b1);

    // Randomized tables, occasional timeouts and host writes.
    for (int r = 0; r < 6; r++) begin
      int sh;
      for (int j = 0; j < 16; j++) rom[j] = $urandom;
      sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      short_addr = sh;
      run_init(sh);
      short_addr = -1;
      if ($urandom_range(0, 1) == 1) do_host($urandom, 1'b1);
    end

    tick(5);
    chk("final_exp_q", exp_q.size(), 0);
    chk("final_ack_q", ack_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
